// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, launches mult/div from E and
// models their latency with a busy counter, requesting D-stage stalls.
//
// Ports:
//   clk, reset      clock and synchronous active-low reset
//   start, md_op    E-stage op valid pulse and op code
//                   (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   rs_val, rt_val  forwarded operands from E
//   md_use_D        D-stage instruction touches HI/LO
//   busy            operation in flight
//   stall_md        stall request to the hazard unit
//   hi, lo          architectural HI/LO registers
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   hi_nxt_q, hi_nxt_d, lo_nxt_q, lo_nxt_d;

    // Arithmetic datapath, evaluated on the launch cycle only.
    logic [63:0] prod_s, prod_u;
    logic [31:0] abs_a, abs_b, div_b, udiv_b;
    logic [31:0] uq, ur, sq, sr, q_u, r_u;
    logic [31:0] res_hi, res_lo;
    logic        is_md, div_zero;

    always_comb begin
        // Sign-extended 64x64 product keeps the low 64 bits of the signed product.
        prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u = {32'b0, rs_val} * {32'b0, rt_val};

        // Signed divide on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
        abs_a  = rs_val[31] ? -rs_val : rs_val;
        abs_b  = rt_val[31] ? -rt_val : rt_val;
        div_zero = (rt_val == 32'd0);
        // Substitute a harmless divisor so no x/0 ever reaches the datapath.
        div_b  = div_zero ? 32'd1 : abs_b;
        udiv_b = div_zero ? 32'd1 : rt_val;

        uq = abs_a / div_b;
        ur = abs_a % div_b;
        sq = (rs_val[31] ^ rt_val[31]) ? -uq : uq;
        sr = rs_val[31] ? -ur : ur;
        q_u = rs_val / udiv_b;
        r_u = rs_val % udiv_b;

        res_hi = hi_q;
        res_lo = lo_q;
        case (md_op[1:0])
            2'd0: {res_hi, res_lo} = prod_s;
            2'd1: {res_hi, res_lo} = prod_u;
            2'd2: if (!div_zero) begin
                res_hi = sr;
                res_lo = sq;
            end
            default: if (!div_zero) begin
                res_hi = r_u;
                res_lo = q_u;
            end
        endcase
    end

    assign is_md = ~md_op[2];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_nxt_d = hi_nxt_q;
        lo_nxt_d = lo_nxt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_md) begin
                        hi_nxt_d = res_hi;
                        lo_nxt_d = res_lo;
                        cnt_d    = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state_d  = RUN;
                    end else if (md_op == 3'd4) begin
                        hi_d = rs_val;
                    end else if (md_op == 3'd5) begin
                        lo_d = rs_val;
                    end
                end
            end
            default: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = hi_nxt_q;
                    lo_d    = lo_nxt_q;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_nxt_q <= '0;
            lo_nxt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_nxt_q <= hi_nxt_d;
            lo_nxt_q <= lo_nxt_d;
        end
    end

    assign busy     = (state_q == RUN);
    // Combinational so D also holds during the launch cycle.
    assign stall_md = md_use_D & (busy | (start & is_md));
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Testbench for mdu_ctrl: directed cases plus random ops
// against a cycle-count reference model of HI/LO.
module tb_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset, start, md_use_D;
    logic [2:0]  md_op;
    logic [31:0] rs_val, rt_val;
    logic        busy, stall_md;
    logic [31:0] hi, lo;

    always #5 clk = ~clk;

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D),
        .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining busy cycles plus a pending result.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_ok;
    int          m_rem;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic compute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        longint p, q, r;
        longint unsigned up;
        sa = a;
        sb = b;
        p_ok = 1'b1;
        case (op)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                {p_hi, p_lo} = p;
            end
            3'd1: begin
                up = {32'b0, a} * {32'b0, b};
                {p_hi, p_lo} = up;
            end
            3'd2: begin
                if (b == 0) p_ok = 1'b0;
                else begin
                    q = longint'(sa) / longint'(sb);
                    r = longint'(sa) % longint'(sb);
                    p_lo = q[31:0];
                    p_hi = r[31:0];
                end
            end
            default: begin
                if (b == 0) p_ok = 1'b0;
                else begin
                    p_lo = a / b;
                    p_hi = a % b;
                end
            end
        endcase
    endtask

    // One cycle: apply inputs, check outputs, advance model at the edge.
    task automatic step(input logic rst, input logic st, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic ud);
        logic exp_stall;
        reset = rst; start = st; md_op = op;
        rs_val = a; rt_val = b; md_use_D = ud;
        #1;
        exp_stall = ud & ((m_rem > 0) | (st & (op < 3'd4)));
        chk("busy", {31'b0, busy}, {31'b0, m_rem > 0});
        chk("stall_md", {31'b0, stall_md}, {31'b0, exp_stall});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        @(posedge clk);
        if (!rst) begin
            m_rem = 0; m_hi = '0; m_lo = '0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && p_ok) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (st) begin
            if (op < 3'd4) begin
                compute(op, a, b);
                m_rem = (op < 3'd2) ? MC : DC;
            end else if (op == 3'd4) m_hi = a;
            else if (op == 3'd5) m_lo = a;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic ud);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 32'd0, 32'd0, ud);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; md_op = 3'd0;
        rs_val = '0; rt_val = '0; md_use_D = 1'b0;
        m_hi = '0; m_lo = '0; p_hi = '0; p_lo = '0; p_ok = 1'b0; m_rem = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        step(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("rst_busy", {31'b0, busy}, 32'd0);

        // MULT 3 * -2 with D stalled throughout.
        step(1'b1, 1'b1, 3'd0, 32'd3, 32'hFFFF_FFFE, 1'b1);
        idle(MC, 1'b1);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);
        chk("mult_stall_end", {31'b0, stall_md}, 32'd0);

        step(1'b1, 1'b1, 3'd3, 32'd7, 32'd2, 1'b0);
        idle(DC, 1'b0);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);

        step(1'b1, 1'b1, 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        idle(DC, 1'b0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        step(1'b1, 1'b1, 3'd4, 32'h1234, 32'd0, 1'b0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo", lo, 32'hFFFF_FFFD);
        chk("mthi_busy", {31'b0, busy}, 32'd0);

        // Divide by zero leaves HI/LO untouched.
        step(1'b1, 1'b1, 3'd4, 32'h55, 32'd0, 1'b0);
        step(1'b1, 1'b1, 3'd5, 32'h55, 32'd0, 1'b0);
        step(1'b1, 1'b1, 3'd2, 32'd9, 32'd0, 1'b0);
        idle(DC, 1'b0);
        chk("dz_hi", hi, 32'h55);
        chk("dz_lo", lo, 32'h55);

        step(1'b1, 1'b1, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DC, 1'b0);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        // Start during busy is ignored.
        step(1'b1, 1'b1, 3'd1, 32'd6, 32'd7, 1'b0);
        step(1'b1, 1'b1, 3'd5, 32'hDEAD, 32'd0, 1'b0);
        step(1'b1, 1'b1, 3'd0, 32'd100, 32'd100, 1'b0);
        idle(MC - 2, 1'b0);
        chk("ign_lo", lo, 32'd42);
        chk("ign_hi", hi, 32'd0);

        // Reset in busy cycle 3 aborts the divide.
        step(1'b1, 1'b1, 3'd3, 32'd100, 32'd3, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b1, 3'd4, 32'h77, 32'd0, 1'b0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        idle(DC + 2, 1'b0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);

        for (int i = 0; i < 600; i++) begin
            logic        r, s, u;
            logic [2:0]  op;
            logic [31:0] a, b;
            r  = ($urandom_range(0, 59) != 0);
            s  = $urandom_range(0, 1) == 1;
            u  = $urandom_range(0, 1) == 1;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 5)) - 32'd2;
            step(r, s, op, a, b, u);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
